// File: rtl/bit_check_sequencer_pkg.sv
// bit_check_sequencer_pkg
//   Shared types and defaults for the bit check sequencer slice.
//   - state_t        : FSM state encoding (IDLE=0, SETTLE=1, SAMPLE=2, REPORT=3)
//   - DEFAULT_*      : default settle window, sample window and error counter width
//   - max_int()      : constant helper used to size the shared window counter
package bit_check_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam int DEFAULT_SETTLE  = 10;
  localparam int DEFAULT_SAMPLES = 8;
  localparam int DEFAULT_CNT_W   = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_check_sequencer_if.sv
// bit_check_sequencer_if
//   Bundles the run request, the observed component bit and the result
//   signals of the bit check sequencer.
//   Signals:
//     start      run request (level sampled, accepted only when idle)
//     exp_val    expected level of dut_bit, captured at acceptance
//     dut_bit    output of the component under check
//     busy       run in progress (acceptance through done cycle)
//     done       one-cycle end-of-run pulse
//     pass/fail  result of the last run, held until the next acceptance
//     err_count  saturating mismatch count of the last/current run
//   Modports:
//     master : board side / bench, drives start, exp_val, dut_bit
//     slave  : the sequencer itself
interface bit_check_sequencer_if
  import bit_check_sequencer_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic             start;
  logic             exp_val;
  logic             dut_bit;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] err_count;

  modport master (
    output start, exp_val, dut_bit,
    input  busy, done, pass, fail, err_count
  );

  modport slave (
    input  start, exp_val, dut_bit,
    output busy, done, pass, fail, err_count
  );

endinterface

// File: rtl/bit_check_sequencer_load_counter.sv
// load_counter
//   Loadable down-counter with a zero flag. The sequencer reuses one
//   instance for both the settle and the sample window.
//   Ports:
//     clk       rising-edge clock
//     rst       asynchronous active-high reset (count -> 0)
//     load      load load_val (takes priority over dec)
//     load_val  value to load
//     dec       decrement by one; holds at zero
//     zero      high while the count is zero
module load_counter
  import bit_check_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bit_check_sequencer.sv
// bit_check_sequencer
//   On-chip self-check for single-bit constant-output components. A run
//   waits SETTLE cycles, then compares dut_bit against the captured
//   expected level on SAMPLES consecutive edges and reports pass/fail and
//   a saturating mismatch count. Start-to-done latency is SETTLE+SAMPLES
//   edges; done is a single-cycle pulse in the REPORT state.
//   Parameters:
//     SETTLE   cycles ignored after acceptance (0 = sample immediately)
//     SAMPLES  number of sampled edges (>= 1)
//     CNT_W    err_count width; must match the connected interface
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset, aborts any run
//     bus   bit_check_sequencer_if.slave (start/exp_val/dut_bit in,
//           busy/done/pass/fail/err_count out)
module bit_check_sequencer
  import bit_check_sequencer_pkg::*;
#(
  parameter int SETTLE  = DEFAULT_SETTLE,
  parameter int SAMPLES = DEFAULT_SAMPLES,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  bit_check_sequencer_if.slave   bus
);

  localparam int               CTR_W       = $clog2(max_int(SETTLE, SAMPLES) + 1);
  localparam logic [CTR_W-1:0] SETTLE_LOAD = CTR_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CTR_W-1:0] SAMPLE_LOAD = CTR_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0] ERR_MAX     = '1;

  state_t           state;
  state_t           state_next;

  logic             ctr_load;
  logic [CTR_W-1:0] ctr_load_val;
  logic             ctr_dec;
  logic             ctr_zero;

  logic             accept;
  logic             sample_en;
  logic             last_sample;
  logic             mismatch;

  logic             exp_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] err_next;
  logic             pass_q;
  logic             fail_q;

  // The counter is loaded with window-1 so that the zero flag marks the
  // final edge of each window, letting the FSM leave on that same edge.
  load_counter #(
    .WIDTH (CTR_W)
  ) u_window_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    ctr_load     = 1'b0;
    ctr_load_val = SAMPLE_LOAD;
    ctr_dec      = 1'b0;
    accept       = 1'b0;
    sample_en    = 1'b0;
    last_sample  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          ctr_load = 1'b1;
          if (SETTLE > 0) begin
            ctr_load_val = SETTLE_LOAD;
            state_next   = ST_SETTLE;
          end else begin
            ctr_load_val = SAMPLE_LOAD;
            state_next   = ST_SAMPLE;
          end
        end
      end
      ST_SETTLE: begin
        if (ctr_zero) begin
          ctr_load     = 1'b1;
          ctr_load_val = SAMPLE_LOAD;
          state_next   = ST_SAMPLE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        if (ctr_zero) begin
          last_sample = 1'b1;
          state_next  = ST_REPORT;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      ST_REPORT: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Saturating increment: because the count can never wrap, err_next==0
  // at the last sample is exactly "no mismatch in this run".
  assign mismatch = sample_en && (bus.dut_bit != exp_q);
  assign err_next = (mismatch && (err_q != ERR_MAX)) ? err_q + CNT_W'(1) : err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q  <= 1'b0;
      err_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (accept) begin
      exp_q  <= bus.exp_val;
      err_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (sample_en) begin
      err_q <= err_next;
      if (last_sample) begin
        pass_q <= (err_next == '0);
        fail_q <= (err_next != '0);
      end
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_REPORT);
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_bit_check_sequencer.sv
// tb_bit_check_sequencer
//   Self-checking bench for bit_check_sequencer. Two instances: dut_a with
//   default windows (SETTLE=10, SAMPLES=8, CNT_W=4) and dut_b with
//   SETTLE=0, SAMPLES=8, CNT_W=2 for the saturation / immediate-sample case.
//   Each run pushes its hand-computed result into a per-DUT queue; a
//   monitor per DUT pops and compares whenever done is seen.
module tb_bit_check_sequencer;
  import bit_check_sequencer_pkg::*;

  localparam int RUN_A = 18;
  localparam int RUN_B = 8;

  typedef struct {
    logic pass;
    logic fail;
    int   err;
    int   done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  bit_check_sequencer_if #(.CNT_W(4)) a_if ();
  bit_check_sequencer_if #(.CNT_W(2)) b_if ();

  bit_check_sequencer #(
    .SETTLE  (10),
    .SAMPLES (8),
    .CNT_W   (4)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  bit_check_sequencer #(
    .SETTLE  (0),
    .SAMPLES (8),
    .CNT_W   (2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen between edges equals the number of the last edge.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: one pop per done cycle; done with an empty queue is an error.
  always @(negedge clk) begin
    exp_t e;
    if (a_if.done === 1'b1) begin
      if (q_a.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL a_unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = q_a.pop_front();
        checkOutput("a_done_cycle", cyc, e.done_cyc);
        checkOutput("a_busy_at_done", a_if.busy, 1);
        checkOutput("a_pass", a_if.pass, e.pass);
        checkOutput("a_fail", a_if.fail, e.fail);
        checkOutput("a_err_count", a_if.err_count, e.err);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_if.done === 1'b1) begin
      if (q_b.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL b_unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = q_b.pop_front();
        checkOutput("b_done_cycle", cyc, e.done_cyc);
        checkOutput("b_pass", b_if.pass, e.pass);
        checkOutput("b_fail", b_if.fail, e.fail);
        checkOutput("b_err_count", b_if.err_count, e.err);
      end
    end
  end

  // One run on dut_a. dut_bit is 'base' except inverted for the edges
  // t0+drop_from .. t0+drop_from+drop_len-1 (t0 = acceptance edge).
  // exp_val is inverted after acceptance to prove it was captured.
  // repulse re-asserts start for one cycle in SETTLE and in SAMPLE.
  task automatic applyStimulus(input logic expv, input logic base, input int drop_from,
                               input int drop_len, input logic repulse,
                               input logic e_pass, input logic e_fail, input int e_err);
    @(negedge clk);
    a_if.start   = 1'b1;
    a_if.exp_val = expv;
    a_if.dut_bit = base;
    q_a.push_back('{e_pass, e_fail, e_err, cyc + 1 + RUN_A});
    for (int k = 1; k <= RUN_A + 1; k++) begin
      @(negedge clk);
      a_if.start   = repulse && (k == 4 || k == 14);
      a_if.exp_val = ~expv;
      a_if.dut_bit = (k >= drop_from && k < drop_from + drop_len) ? ~base : base;
      if (k == RUN_A) begin
        checkOutput("a_busy_in_sample", a_if.busy, 1);
      end
    end
    @(negedge clk);
    checkOutput("a_busy_after_run", a_if.busy, 0);
    checkOutput("a_pass_held", a_if.pass, e_pass);
    checkOutput("a_fail_held", a_if.fail, e_fail);
    checkOutput("a_err_held", a_if.err_count, e_err);
  endtask

  // One run on dut_b; dut_bit inverted only for edge t0+drop_k.
  task automatic applyStimulusB(input logic base, input int drop_k,
                                input logic e_pass, input logic e_fail, input int e_err);
    @(negedge clk);
    b_if.start   = 1'b1;
    b_if.exp_val = 1'b1;
    b_if.dut_bit = base;
    q_b.push_back('{e_pass, e_fail, e_err, cyc + 1 + RUN_B});
    for (int k = 0; k <= RUN_B + 1; k++) begin
      b_if.dut_bit = (k == drop_k) ? ~base : base;
      @(negedge clk);
      b_if.start = 1'b0;
    end
    checkOutput("b_busy_after_run", b_if.busy, 0);
    checkOutput("b_fail_held", b_if.fail, e_fail);
  endtask

  initial begin
    rst          = 1'b1;
    a_if.start   = 1'b0;
    a_if.exp_val = 1'b0;
    a_if.dut_bit = 1'b0;
    b_if.start   = 1'b0;
    b_if.exp_val = 1'b0;
    b_if.dut_bit = 1'b0;
    #1;
    checkOutput("reset_busy", a_if.busy, 0);
    checkOutput("reset_done", a_if.done, 0);
    checkOutput("reset_pass", a_if.pass, 0);
    checkOutput("reset_fail", a_if.fail, 0);
    checkOutput("reset_err", a_if.err_count, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] setbit pass, stuck-at-0 fail, sample/settle drops");
    applyStimulus(1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 8);
    applyStimulus(1'b1, 1'b1, 13, 3, 1'b0, 1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 3, 3, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 11, 1, 1'b0, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 0);

    $display("[TB] start held high across two runs");
    @(negedge clk);
    a_if.start   = 1'b1;
    a_if.exp_val = 1'b1;
    a_if.dut_bit = 1'b0;
    q_a.push_back('{1'b0, 1'b1, 8, cyc + 1 + RUN_A});
    q_a.push_back('{1'b1, 1'b0, 0, cyc + 1 + 2 * RUN_A + 2});
    for (int k = 1; k <= 2 * RUN_A + 4; k++) begin
      @(negedge clk);
      if (k == RUN_A + 1) a_if.dut_bit = 1'b1;
      if (k == RUN_A + 2) begin
        checkOutput("held_idle_gap_busy", a_if.busy, 0);
        checkOutput("held_idle_gap_fail", a_if.fail, 1);
      end
      if (k == RUN_A + 3) begin
        checkOutput("held_reaccept_busy", a_if.busy, 1);
        checkOutput("held_reaccept_pass", a_if.pass, 0);
        checkOutput("held_reaccept_fail", a_if.fail, 0);
        checkOutput("held_reaccept_err", a_if.err_count, 0);
        a_if.start = 1'b0;
      end
    end
    checkOutput("held_end_busy", a_if.busy, 0);

    $display("[TB] asynchronous reset mid-sample");
    @(negedge clk);
    a_if.start   = 1'b1;
    a_if.exp_val = 1'b1;
    a_if.dut_bit = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      a_if.start = 1'b0;
    end
    checkOutput("mid_run_err", a_if.err_count, 3);
    checkOutput("mid_run_busy", a_if.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", a_if.busy, 0);
    checkOutput("abort_done", a_if.done, 0);
    checkOutput("abort_pass", a_if.pass, 0);
    checkOutput("abort_fail", a_if.fail, 0);
    checkOutput("abort_err", a_if.err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (RUN_A + 4) @(negedge clk);
    checkOutput("after_abort_busy", a_if.busy, 0);
    checkOutput("after_abort_fail", a_if.fail, 0);
    applyStimulus(1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 0);

    $display("[TB] narrow counter, zero settle");
    applyStimulusB(1'b0, -1, 1'b0, 1'b1, 3);
    applyStimulusB(1'b1, -1, 1'b1, 1'b0, 0);
    applyStimulusB(1'b1, 1, 1'b0, 1'b1, 1);

    repeat (3) @(negedge clk);
    checkOutput("a_queue_drained", q_a.size(), 0);
    checkOutput("b_queue_drained", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
